// File: rtl/game_pkg.sv
// Shared game definitions: control-unit round-end state encodings and the
// countdown FSM state type.
package game_pkg;

  localparam logic [3:0] GS_DRAW = 4'b0110;
  localparam logic [3:0] GS_GOOD = 4'b1000;
  localparam logic [3:0] GS_OUCH = 4'b1001;
  localparam logic [3:0] GS_WIN  = 4'b1010;
  localparam logic [3:0] GS_LOSE = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_GO    = 2'd2
  } cd_state_t;

  function automatic logic is_round_end(input logic [3:0] game_state);
    return (game_state == GS_DRAW) || (game_state == GS_GOOD) ||
           (game_state == GS_OUCH) || (game_state == GS_WIN)  ||
           (game_state == GS_LOSE);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Countdown prescaler: while enabled, pulses TICK once every DIV cycles,
// starting from zero each time it is enabled.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int W = $clog2(DIV + 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign TICK = EN && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ready_countdown.sv
// Collects per-player ready pulses and, once every seated player is ready,
// runs a registered countdown on NUM and then raises OK until the round ends.
module ready_countdown
  import game_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int NUM_W       = 4,
  parameter int COUNT_START = 5,
  parameter int TICK_DIV    = 50_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PLAYERS-1:0] READY_IN,
  input  logic [PLAYERS-1:0] PRESENT,
  input  logic [3:0]         STATE,
  output logic [NUM_W-1:0]   NUM,
  output logic               OK
);

  localparam logic [NUM_W-1:0] START = NUM_W'(COUNT_START);

  logic [PLAYERS-1:0] keep;
  logic               round_end;
  logic               all_ready;
  logic               count_en;
  logic               tick;
  cd_state_t          state;

  assign round_end = is_round_end(STATE);
  // An absent player counts as ready, but an empty table is never ready.
  assign all_ready = (|PRESENT) && (&(keep | ~PRESENT));
  assign count_en  = (state == S_COUNT);

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (count_en),
    .TICK (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST || round_end) begin
      keep <= '0;
    end else begin
      keep <= keep | READY_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || round_end) begin
      state <= S_IDLE;
      NUM   <= '0;
      OK    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          NUM <= '0;
          OK  <= 1'b0;
          if (all_ready) begin
            if (COUNT_START == 0) begin
              state <= S_GO;
              OK    <= 1'b1;
            end else begin
              state <= S_COUNT;
              NUM   <= START;
            end
          end
        end
        S_COUNT: begin
          if (!all_ready) begin
            state <= S_IDLE;
            NUM   <= '0;
            OK    <= 1'b0;
          end else if (tick) begin
            // Last step lands on GO; the <= guard keeps NUM from wrapping.
            if (NUM <= 1) begin
              state <= S_GO;
              NUM   <= '0;
              OK    <= 1'b1;
            end else begin
              NUM <= NUM - 1'b1;
            end
          end
        end
        S_GO: begin
          NUM <= '0;
          OK  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          NUM   <= '0;
          OK    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ready_countdown.sv
// Bench for ready_countdown: two instances (COUNT_START=3 and 0) share all
// inputs; directed scenarios then random traffic, checked against a model.
module tb_ready_countdown;

  localparam int TD = 4;

  logic       CLK;
  logic       RST;
  logic [1:0] READY_IN;
  logic [1:0] PRESENT;
  logic [3:0] STATE;
  logic [3:0] num3, num0;
  logic       ok3, ok0;

  ready_countdown #(.PLAYERS(2), .NUM_W(4), .COUNT_START(3), .TICK_DIV(TD)) dut3 (
    .CLK(CLK), .RST(RST), .READY_IN(READY_IN), .PRESENT(PRESENT),
    .STATE(STATE), .NUM(num3), .OK(ok3)
  );

  ready_countdown #(.PLAYERS(2), .NUM_W(4), .COUNT_START(0), .TICK_DIV(TD)) dut0 (
    .CLK(CLK), .RST(RST), .READY_IN(READY_IN), .PRESENT(PRESENT),
    .STATE(STATE), .NUM(num0), .OK(ok0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int    n_total = 0;
  int    n_bad   = 0;
  string phase   = "init";

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%0d exp=%0d at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Model: per instance, ready flags, a mode (0 waiting, 1 counting, 2 go)
  // and the number of cycles spent counting so far.
  int         cs[2] = '{3, 0};
  int         m_mode[2];
  int         m_elapsed[2];
  logic [1:0] m_keep[2];

  function automatic bit round_end_state(input logic [3:0] s);
    return s == 4'd6 || s == 4'd8 || s == 4'd9 || s == 4'd10 || s == 4'd11;
  endfunction

  task automatic model_step(input logic r, input logic [1:0] rdy,
                            input logic [1:0] pres, input logic [3:0] st);
    for (int i = 0; i < 2; i++) begin
      bit re = round_end_state(st);
      bit ar = (pres != 2'b00) && ((m_keep[i] | ~pres) == 2'b11);
      if (r) begin
        m_keep[i] = 2'b00; m_mode[i] = 0; m_elapsed[i] = 0;
      end else begin
        if (re) begin
          m_mode[i] = 0;
        end else if (m_mode[i] == 0) begin
          if (ar) begin
            m_mode[i] = (cs[i] == 0) ? 2 : 1;
            m_elapsed[i] = 0;
          end
        end else if (m_mode[i] == 1) begin
          if (!ar) m_mode[i] = 0;
          else begin
            m_elapsed[i]++;
            if (m_elapsed[i] >= cs[i] * TD) m_mode[i] = 2;
          end
        end
        m_keep[i] = re ? 2'b00 : (m_keep[i] | rdy);
      end
    end
  endtask

  function automatic int exp_num(input int i);
    return (m_mode[i] == 1) ? cs[i] - m_elapsed[i] / TD : 0;
  endfunction

  task automatic cycle(input logic r, input logic [1:0] rdy,
                       input logic [1:0] pres, input logic [3:0] st);
    RST = r; READY_IN = rdy; PRESENT = pres; STATE = st;
    @(posedge CLK);
    #1;
    model_step(r, rdy, pres, st);
    check("num3", int'(num3), exp_num(0));
    check("ok3",  int'(ok3),  int'(m_mode[0] == 2));
    check("num0", int'(num0), exp_num(1));
    check("ok0",  int'(ok0),  int'(m_mode[1] == 2));
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] pres);
    for (int k = 0; k < n; k++) cycle(1'b0, 2'b00, pres, 4'b0000);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_elapsed[i] = 0; m_keep[i] = 2'b00;
    end
    RST = 1'b1; READY_IN = '0; PRESENT = '0; STATE = '0;

    phase = "reset";
    cycle(1'b1, 2'b11, 2'b11, 4'b0000);
    cycle(1'b1, 2'b00, 2'b11, 4'b0000);
    idle_cycles(2, 2'b11);

    phase = "two_players";
    cycle(1'b0, 2'b01, 2'b11, 4'b0000);
    idle_cycles(2, 2'b11);
    cycle(1'b0, 2'b10, 2'b11, 4'b0000);
    idle_cycles(18, 2'b11);
    cycle(1'b0, 2'b00, 2'b11, 4'b1010);

    phase = "absent_player";
    cycle(1'b0, 2'b01, 2'b01, 4'b0000);
    idle_cycles(16, 2'b01);
    cycle(1'b0, 2'b00, 2'b01, 4'b1000);

    phase = "abort_count";
    cycle(1'b0, 2'b11, 2'b11, 4'b0000);
    idle_cycles(6, 2'b11);
    check("num3_mid", int'(num3), 2);
    cycle(1'b0, 2'b00, 2'b11, 4'b1010);
    check("num3_abort", int'(num3), 0);
    idle_cycles(10, 2'b11);

    phase = "clear_priority";
    cycle(1'b0, 2'b11, 2'b11, 4'b0110);
    idle_cycles(8, 2'b11);

    phase = "reset_in_go";
    cycle(1'b0, 2'b11, 2'b11, 4'b0000);
    idle_cycles(16, 2'b11);
    check("ok3_go", int'(ok3), 1);
    cycle(1'b1, 2'b00, 2'b11, 4'b0000);
    idle_cycles(10, 2'b11);
    cycle(1'b0, 2'b11, 2'b11, 4'b0000);
    idle_cycles(3, 2'b11);

    phase = "presence_drop";
    cycle(1'b0, 2'b00, 2'b11, 4'b1001);
    cycle(1'b0, 2'b01, 2'b11, 4'b0000);
    idle_cycles(2, 2'b01);
    idle_cycles(3, 2'b11);
    idle_cycles(3, 2'b00);

    phase = "random";
    begin
      logic [1:0] pres = 2'b11;
      for (int k = 0; k < 3000; k++) begin
        logic       r  = ($urandom_range(0, 99) == 0);
        logic [1:0] rdy;
        logic [3:0] st = 4'b0000;
        rdy[0] = ($urandom_range(0, 4) == 0);
        rdy[1] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 7) == 0) st = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 49) == 0) pres = 2'($urandom_range(0, 3));
        cycle(r, rdy, pres, st);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ready_countdown.md
READY_COUNTDOWN -- requirements
Module: ready_countdown

Interface
REQ-001 SHALL have parameter PLAYERS, default 2: number of player ready channels (1..8).
REQ-002 SHALL have parameter NUM_W, default 4: width of NUM.
REQ-003 SHALL have parameter COUNT_START, default 5: countdown start value (0..2^NUM_W-1).
REQ-004 SHALL have parameter TICK_DIV, default 50_000_000: CLK cycles per countdown step (>=1).
REQ-005 SHALL have port CLK, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port READY_IN, input, PLAYERS: per-player one-cycle ready pulse from the control unit.
REQ-008 SHALL have port PRESENT, input, PLAYERS: 1 = player seated; 0 = player counts as ready.
REQ-009 SHALL have port STATE, input, 4: game state from the control unit.
REQ-010 SHALL have port NUM, output, NUM_W: countdown digit to the display block.
REQ-011 SHALL have port OK, output, 1: start-go flag to the control unit.

Function
REQ-012 SHALL hold a per-player latch keep[i]; set on the edge after READY_IN[i]=1, held otherwise.
REQ-013 SHALL treat STATE in {0110 DRAW, 1000 GOOD, 1001 OUCH, 1010 WIN, 1011 LOSE} as a round-end event.
REQ-014 SHALL, on a round-end event, clear all keep[i], with clear taking priority over a same-cycle READY_IN[i].
REQ-015 SHALL form all_ready = AND over i of (keep[i] OR NOT PRESENT[i]), forced to 0 when PRESENT is all-zero.
REQ-016 SHALL implement FSM states IDLE, COUNT, GO.
REQ-017 IDLE: NUM=0, OK=0; when all_ready=1 and no round-end event, go to COUNT on the next edge, with NUM=COUNT_START and prescaler=0.
REQ-018 IDLE with COUNT_START=0: go directly to GO instead of COUNT.
REQ-019 COUNT: the prescaler increments every cycle and wraps at TICK_DIV-1; on that wrap cycle (tick), NUM decrements by 1.
REQ-020 COUNT: a tick with NUM=1 goes to GO, with NUM=0 and OK=1 on the same edge.
REQ-021 GO: OK=1 and NUM=0 are held until a round-end event.
REQ-022 Any state: a round-end event goes to IDLE on the next edge, with NUM=0 and OK=0; this has priority over tick and all_ready.
REQ-023 COUNT: if all_ready falls to 0 (PRESENT change), return to IDLE with NUM=0 and no OK.
REQ-024 Latency: READY_IN completing all_ready sampled at edge k puts NUM=COUNT_START after edge k+1, and the first decrement after edge k+1+TICK_DIV.
REQ-025 NUM and OK SHALL be registered outputs with no combinational path from the inputs.
REQ-026 NUM arithmetic SHALL be unsigned NUM_W-bit and SHALL never underflow below 0.
REQ-027 The prescaler SHALL be $clog2(TICK_DIV+1) bits wide, and SHALL count only in COUNT.

Reset
REQ-028 RST=1 at an edge SHALL clear keep, the prescaler, the FSM (IDLE), NUM=0 and OK=0, overriding all other inputs.
REQ-029 Reset asserted mid-COUNT or in GO SHALL abort without an OK pulse, and keep SHALL need fresh READY_IN after release.
REQ-030 SHALL give no initial-block dependence, so the reset state is the only defined start state.

Structure
REQ-031 The round-end STATE encodings and the FSM state typedef SHALL live in shared package game_pkg.
REQ-032 The prescaler SHALL be sub-module tick_gen (params DIV; ports CLK, RST, EN, TICK).
REQ-033 The block SHALL contain no other sub-modules, and RTL SHALL be 120-400 lines.

Verification (PLAYERS=2, COUNT_START=3, TICK_DIV=4 unless stated)
REQ-034 SHALL test: PRESENT=11, pulse READY_IN=01 then 10 three cycles later -> NUM stays 0 until the edge after the second keep, then 3,2,1 each 4 cycles, then NUM=0 and OK=1 held.
REQ-035 SHALL test: PRESENT=01, pulse READY_IN=01 -> countdown starts without player 1, and OK=1 after 12 cycles in COUNT.
REQ-036 SHALL test: during COUNT with NUM=2, STATE=1010 for 1 cycle -> next edge NUM=0 and OK=0 in IDLE, and keep cleared so no restart without new pulses.
REQ-037 SHALL test: same-cycle READY_IN=11 and STATE=0110 -> keep stays 00 and the FSM stays IDLE.
REQ-038 SHALL test: RST=1 for 1 cycle in GO -> NUM=0 and OK=0 next edge, and a re-ready is required.
REQ-039 SHALL test: COUNT_START=0 -> after both pulses, OK=1 two edges after the last READY_IN, and NUM stays 0.
